// File: rtl/ap_drv_pkg.sv
// Shared types and constants for the ap_ctrl_chain initiator (ap_ctrl_driver).
package ap_drv_pkg;

  // Run-level controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } ap_drv_state_e;

  // Reset/run-start value of the minimum-latency tracker: all-ones, so the
  // first measured latency always replaces it. Sliced down to CYC_W by users
  // (supports CYC_W up to 64).
  localparam logic [63:0] LAT_INIT = '1;

endpackage

// File: rtl/ap_drv_ts_fifo.sv
// Timestamp FIFO: DEPTH entries of W bits, one write and one read port,
// simultaneous push+pop allowed, occupancy count exported for throttling.
// The caller guarantees no push when full and no pop when empty.
module ap_drv_ts_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer wrap and occupancy bookkeeping for the next cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage and pointer registers; reset wipes contents as well as pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/ap_ctrl_driver.sv
// Initiator for the HLS ap_ctrl_chain handshake. Issues a programmed number
// of transactions, keeps at most MAX_OUT in flight, measures start->done
// latency per transaction and pulses finish at the end of the run.
// Optional feature macro: AP_DRV_CONT_STALL_EN adds cfg_stall[7:0], which
// delays ap_continue by that many cycles after ap_done rises.
module ap_ctrl_driver
  import ap_drv_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned CYC_W   = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_txn,
`ifdef AP_DRV_CONT_STALL_EN
  input  logic [7:0]       cfg_stall,
`endif
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CYC_W-1:0] lat_min,
  output logic [CYC_W-1:0] lat_max,
  output logic             err_spur_done
);

  localparam int unsigned   CW         = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_OUT_C  = CW'(MAX_OUT);
  localparam logic [CYC_W-1:0] LAT_INIT_W = LAT_INIT[CYC_W-1:0];

  ap_drv_state_e    state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [CYC_W-1:0] lat_min_q, lat_min_d;
  logic [CYC_W-1:0] lat_max_q, lat_max_d;
  logic             err_q, err_d;
  logic             start_q, start_d;

  logic             cfg_acc;
  logic             run_or_drain;
  logic             cont;
  logic             start_fire;
  logic             done_fire;
  logic             spur;
  logic             done_ok;
  logic [CW-1:0]    outst;
  logic [CW-1:0]    outst_d;
  logic             fifo_empty;
  logic [CYC_W-1:0] ts_head;
  logic [CYC_W-1:0] lat_cur;

  assign cfg_acc      = (state_q == IDLE) && cfg_start;
  assign run_or_drain = (state_q == RUN) || (state_q == DRAIN);
  assign start_fire   = start_q && ap_ready;
  assign done_fire    = ap_done && cont;
  // A done with nothing in flight cannot belong to any transaction we issued
  assign spur         = ap_done && fifo_empty;
  assign done_ok      = done_fire && !fifo_empty;
  // Modular subtraction makes cycle-counter wrap harmless
  assign lat_cur      = cycle_q - ts_head;

  // Start timestamps of in-flight transactions; occupancy doubles as outstanding count
  ap_drv_ts_fifo #(
    .DEPTH (MAX_OUT),
    .W     (CYC_W)
  ) u_ts_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (start_fire),
    .push_data_i (cycle_q),
    .pop_i       (done_ok),
    .pop_data_o  (ts_head),
    .count_o     (outst),
    .empty_o     (fifo_empty)
  );

`ifdef AP_DRV_CONT_STALL_EN
  logic [7:0] stall_q;
  logic [7:0] wait_q, wait_d;

  // Count how long the current done has been waiting; release continue once it reaches cfg_stall
  always_comb begin
    wait_d = wait_q;
    if (!ap_done || done_fire || fifo_empty || !run_or_drain) begin
      wait_d = '0;
    end else if (wait_q != stall_q) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Stall setting is captured with the run; wait counter tracks the pending done
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else begin
      if (cfg_acc) begin
        stall_q <= cfg_stall;
      end
      wait_q <= wait_d;
    end
  end

  assign cont = run_or_drain && (wait_q == stall_q);
`else
  assign cont = run_or_drain;
`endif

  // Run sequencing: a zero-length run goes straight to the finish state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_num_txn == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issued_q == num_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (done_q == num_q) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Run statistics: cleared by an accepted cfg_start, updated by starts and consumed dones
  always_comb begin
    num_d     = num_q;
    issued_d  = issued_q;
    done_d    = done_q;
    cycle_d   = cycle_q;
    lat_min_d = lat_min_q;
    lat_max_d = lat_max_q;
    err_d     = err_q;
    if (cfg_acc) begin
      num_d     = cfg_num_txn;
      issued_d  = '0;
      done_d    = '0;
      cycle_d   = '0;
      lat_min_d = LAT_INIT_W;
      lat_max_d = '0;
      err_d     = 1'b0;
    end else begin
      if (start_fire) begin
        issued_d = issued_q + CNT_W'(1);
      end
      if (done_ok) begin
        done_d = done_q + CNT_W'(1);
        if (lat_cur < lat_min_q) begin
          lat_min_d = lat_cur;
        end
        if (lat_cur > lat_max_q) begin
          lat_max_d = lat_cur;
        end
      end
      if (spur) begin
        err_d = 1'b1;
      end
      if (state_q != IDLE) begin
        cycle_d = cycle_q + CYC_W'(1);
      end
    end
  end

  // Outstanding count as it will be after this edge (ready+done together cancel out)
  always_comb begin
    outst_d = outst;
    if (start_fire && !done_ok) begin
      outst_d = outst + CW'(1);
    end else if (!start_fire && done_ok) begin
      outst_d = outst - CW'(1);
    end
  end

  // ap_start: once raised it waits for ap_ready; otherwise decided from next-cycle
  // counts so a new start can follow the accepting edge immediately
  always_comb begin
    start_d = 1'b0;
    if (start_q && !ap_ready) begin
      start_d = 1'b1;
    end else if ((state_d == RUN) && (issued_d < num_d) && (outst_d < MAX_OUT_C)) begin
      start_d = 1'b1;
    end
  end

  // Controller registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      num_q     <= '0;
      issued_q  <= '0;
      done_q    <= '0;
      cycle_q   <= '0;
      lat_min_q <= LAT_INIT_W;
      lat_max_q <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      issued_q  <= issued_d;
      done_q    <= done_d;
      cycle_q   <= cycle_d;
      lat_min_q <= lat_min_d;
      lat_max_q <= lat_max_d;
      err_q     <= err_d;
      start_q   <= start_d;
    end
  end

  assign ap_start      = start_q;
  assign ap_continue   = cont;
  assign busy          = (state_q != IDLE);
  assign finish        = (state_q == FIN);
  assign issued_cnt    = issued_q;
  assign done_cnt      = done_q;
  assign lat_min       = lat_min_q;
  assign lat_max       = lat_max_q;
  assign err_spur_done = err_q;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Bench for ap_ctrl_driver: a behavioural HLS kernel answers ap_start/ap_done,
// a timestamp scoreboard predicts latencies, and table rows set kernel timing.
module tb_ap_ctrl_driver;

  localparam int CNT_W   = 32;
  localparam int CYC_W   = 32;
  localparam int MAX_OUT = 4;

  logic             clock;
  logic             reset_n;
  logic             cfg_start;
  logic [CNT_W-1:0] cfg_num_txn;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             busy;
  logic             finish;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [CYC_W-1:0] lat_min;
  logic [CYC_W-1:0] lat_max;
  logic             err_spur_done;

  ap_ctrl_driver #(
    .CNT_W   (CNT_W),
    .CYC_W   (CYC_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cfg_start     (cfg_start),
    .cfg_num_txn   (cfg_num_txn),
`ifdef AP_DRV_CONT_STALL_EN
    .cfg_stall     (8'd0),
`endif
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_continue   (ap_continue),
    .busy          (busy),
    .finish        (finish),
    .issued_cnt    (issued_cnt),
    .done_cnt      (done_cnt),
    .lat_min       (lat_min),
    .lat_max       (lat_max),
    .err_spur_done (err_spur_done)
  );

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Overall time guard so the bench can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got no end, expected end of test");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    int num;
    int rdly;
    int ddly;
    int gate;
    int expIssued;
    int expDone;
    int expMaxOut;
    bit latKnown;
    int expLat;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int passes = 0;

  int cyc;
  int hiCnt;
  int outstanding;
  int maxOut;
  int overLimit;
  int startedTotal;
  int curRdly;
  int curDdly;
  int curGate;
  int doneAt[$];
  int sbTs[$];
  logic [31:0] sbMin;
  logic [31:0] sbMax;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetKernel(input int rdly, input int ddly, input int gate);
    cyc          = 0;
    hiCnt        = 0;
    outstanding  = 0;
    maxOut       = 0;
    overLimit    = 0;
    startedTotal = 0;
    curRdly      = rdly;
    curDdly      = ddly;
    curGate      = gate;
    doneAt.delete();
    sbTs.delete();
    sbMin        = '1;
    sbMax        = '0;
    ap_ready     = 1'b0;
    ap_done      = 1'b0;
  endtask

  // One kernel cycle, executed at a falling edge: look at the DUT, decide
  // ready/done for the coming rising edge and book-keep what will fire there.
  task automatic kernelStep();
    logic startNow;
    logic contNow;
    logic rdy;
    logic dn;
    int   ts;
    int   dummy;
    int   latency;
    startNow = ap_start;
    contNow  = ap_continue;
    if (startNow && (outstanding >= MAX_OUT)) overLimit++;
    if (outstanding > maxOut) maxOut = outstanding;
    if (startNow) hiCnt++;
    rdy = startNow && (hiCnt > curRdly);
    dn  = (doneAt.size() > 0) && (doneAt[0] <= cyc) && (startedTotal >= curGate);
    ap_ready = rdy;
    ap_done  = dn;
    if (rdy) begin
      doneAt.push_back(cyc + curDdly);
      sbTs.push_back(cyc);
      startedTotal++;
      hiCnt = 0;
      outstanding++;
    end
    if (dn && contNow) begin
      dummy   = doneAt.pop_front();
      ts      = sbTs.pop_front();
      latency = cyc - ts;
      if (32'(latency) < sbMin) sbMin = 32'(latency);
      if (32'(latency) > sbMax) sbMax = 32'(latency);
      outstanding--;
    end
    cyc++;
  endtask

  // Run one table row end to end and compare the run results
  task automatic applyStimulus(input int idx);
    bit    got;
    string p;
    p = $sformatf("v%0d", idx);
    resetKernel(vecs[idx].rdly, vecs[idx].ddly, vecs[idx].gate);
    @(negedge clock);
    cfg_num_txn = CNT_W'(vecs[idx].num);
    cfg_start   = 1'b1;
    @(negedge clock);
    cfg_start   = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      if (finish) begin
        got = 1'b1;
      end else begin
        kernelStep();
        @(negedge clock);
      end
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    checkOutput({p, "_finished"}, 64'(got), 64'd1);
    checkOutput({p, "_issued"}, 64'(issued_cnt), 64'(vecs[idx].expIssued));
    checkOutput({p, "_done"}, 64'(done_cnt), 64'(vecs[idx].expDone));
    checkOutput({p, "_err"}, 64'(err_spur_done), 64'd0);
    checkOutput({p, "_lat_min_sb"}, 64'(lat_min), 64'(sbMin));
    checkOutput({p, "_lat_max_sb"}, 64'(lat_max), 64'(sbMax));
    checkOutput({p, "_max_outstanding"}, 64'(maxOut), 64'(vecs[idx].expMaxOut));
    checkOutput({p, "_start_over_limit"}, 64'(overLimit), 64'd0);
    if (vecs[idx].latKnown) begin
      checkOutput({p, "_lat_min"}, 64'(lat_min), 64'(vecs[idx].expLat));
      checkOutput({p, "_lat_max"}, 64'(lat_max), 64'(vecs[idx].expLat));
    end
    @(negedge clock);
    checkOutput({p, "_finish_one_cycle"}, 64'(finish), 64'd0);
    checkOutput({p, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int   n;
    logic startSeen;
    bit   reached;

    reset_n     = 1'b0;
    cfg_start   = 1'b0;
    cfg_num_txn = '0;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;

    vecs[0] = '{num: 1,  rdly: 2, ddly: 5, gate: 0, expIssued: 1,  expDone: 1,  expMaxOut: 1, latKnown: 1'b1, expLat: 5};
    vecs[1] = '{num: 8,  rdly: 0, ddly: 1, gate: 4, expIssued: 8,  expDone: 8,  expMaxOut: 4, latKnown: 1'b0, expLat: 0};
    vecs[2] = '{num: 16, rdly: 0, ddly: 1, gate: 0, expIssued: 16, expDone: 16, expMaxOut: 1, latKnown: 1'b1, expLat: 1};
    vecs[3] = '{num: 6,  rdly: 1, ddly: 3, gate: 0, expIssued: 6,  expDone: 6,  expMaxOut: 2, latKnown: 1'b1, expLat: 3};

    repeat (3) @(negedge clock);
    checkOutput("reset_ap_start", 64'(ap_start), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_finish", 64'(finish), 64'd0);
    checkOutput("reset_continue", 64'(ap_continue), 64'd0);
    checkOutput("reset_issued", 64'(issued_cnt), 64'd0);
    checkOutput("reset_done", 64'(done_cnt), 64'd0);
    checkOutput("reset_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
    checkOutput("reset_lat_max", 64'(lat_max), 64'd0);
    checkOutput("reset_err", 64'(err_spur_done), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(i);
    end

    // Zero-length run: finish follows quickly, kernel never sees a start
    @(negedge clock);
    cfg_num_txn = '0;
    cfg_start   = 1'b1;
    @(negedge clock);
    cfg_start   = 1'b0;
    n           = 1;
    startSeen   = ap_start;
    while (!finish && n < 6) begin
      @(negedge clock);
      n++;
      startSeen = startSeen | ap_start;
    end
    checkOutput("zero_finish", 64'(finish), 64'd1);
    checkOutput("zero_finish_within_2", 64'(n <= 2), 64'd1);
    checkOutput("zero_no_start", 64'(startSeen), 64'd0);
    checkOutput("zero_issued", 64'(issued_cnt), 64'd0);
    @(negedge clock);
    checkOutput("zero_finish_pulse", 64'(finish), 64'd0);

    // Spurious done while idle: sticky error, no count
    @(negedge clock);
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("spur_err_sticky", 64'(err_spur_done), 64'd1);
    checkOutput("spur_done_cnt", 64'(done_cnt), 64'd0);
    checkOutput("spur_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a run with 3 outstanding
    resetKernel(0, 1, 1000);
    cfg_num_txn = CNT_W'(8);
    cfg_start   = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
    reached   = 1'b0;
    for (int k = 0; k < 50 && !reached; k++) begin
      kernelStep();
      @(negedge clock);
      if (outstanding == 3) reached = 1'b1;
    end
    checkOutput("rst_reached_3_outstanding", 64'(reached), 64'd1);
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_ap_start", 64'(ap_start), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_issued", 64'(issued_cnt), 64'd0);
    checkOutput("rst_done", 64'(done_cnt), 64'd0);
    checkOutput("rst_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
    checkOutput("rst_err", 64'(err_spur_done), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    applyStimulus(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
